// File: rtl/keypad_entry_if.sv
// Keypad entry bundle: key events in, packed code and status pulses out.
// The master drives keys and lock; the slave is the entry buffer.
interface keypad_entry_if;
  logic         key_valid;
  logic [3:0]   key_code;
  logic         lock;
  logic [127:0] input_value;
  logic [5:0]   digit_count;
  logic         confirm;
  logic         entry_error;
  logic         entry_timeout;

  modport master (
    output key_valid, key_code, lock,
    input  input_value, digit_count,
    input  confirm, entry_error, entry_timeout
  );

  modport slave (
    input  key_valid, key_code, lock,
    output input_value, digit_count,
    output confirm, entry_error, entry_timeout
  );
endinterface

// File: rtl/keypad_entry_buffer.sv
// Packs keypad digits into a 128-bit 0xF-padded code word with
// backspace, clear, ENTER confirm, idle timeout and lockout.
module keypad_entry_buffer #(
  parameter int MAX_DIGITS     = 32,
  parameter int MIN_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input logic            clk,
  input logic            rst_n,
  keypad_entry_if.slave  kp
);
  localparam int IW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0] CMAX = 6'(MAX_DIGITS);
  localparam logic [5:0] CMIN = 6'(MIN_DIGITS);

  typedef enum logic [1:0] {
    EMPTY, ENTRY, CONFIRM
  } state_t;

  state_t        state_q, state_d;
  logic [127:0]  val_q, val_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          conf_q, conf_d;
  logic          err_q, err_d;
  logic          to_q, to_d;

  logic key;
  logic is_dig, is_clr, is_bs, is_ent;

  assign key = kp.key_valid && !kp.lock;

  // Classify the incoming key code.
  always_comb begin
    is_dig = 1'b0;
    is_clr = 1'b0;
    is_bs  = 1'b0;
    is_ent = 1'b0;
    unique case (1'b1)
      (kp.key_code <= 4'h9): is_dig = 1'b1;
      (kp.key_code == 4'hC): is_clr = 1'b1;
      (kp.key_code == 4'hE): is_bs  = 1'b1;
      (kp.key_code == 4'hF): is_ent = 1'b1;
      default: ;
    endcase
  end

  // Register all state and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      val_q   <= '1;
      cnt_q   <= '0;
      idle_q  <= '0;
      conf_q  <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      conf_q  <= conf_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  // Next-state: key handling, confirm release and idle timer.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    conf_d  = 1'b0;
    err_d   = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      CONFIRM: begin
        state_d = EMPTY;
        val_d   = '1;
        cnt_d   = '0;
        idle_d  = '0;
      end
      default: begin
        if (key && is_dig) begin
          idle_d = '0;
          if (cnt_q == CMAX) begin
            err_d = 1'b1;
          end else begin
            val_d   = {val_q[123:0], kp.key_code};
            cnt_d   = cnt_q + 6'd1;
            state_d = ENTRY;
          end
        end else if (key && is_bs) begin
          idle_d = '0;
          if (cnt_q != 6'd0) begin
            val_d = {4'hF, val_q[127:4]};
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd1) state_d = EMPTY;
          end
        end else if (key && is_clr) begin
          idle_d  = '0;
          val_d   = '1;
          cnt_d   = '0;
          state_d = EMPTY;
        end else if (key && is_ent) begin
          idle_d = '0;
          if (cnt_q >= CMIN) begin
            state_d = CONFIRM;
            conf_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (state_q == ENTRY && !kp.lock) begin
          if (idle_q == LAST) begin
            val_d   = '1;
            cnt_d   = '0;
            state_d = EMPTY;
            idle_d  = '0;
            to_d    = 1'b1;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
        if (state_d != ENTRY) idle_d = '0;
      end
    endcase
  end

  assign kp.input_value   = val_q;
  assign kp.digit_count   = cnt_q;
  assign kp.confirm       = conf_q;
  assign kp.entry_error   = err_q;
  assign kp.entry_timeout = to_q;
endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Scoreboard bench for keypad_entry_buffer: directed key
// sequences with hand-written expected outputs.
module tb_keypad_entry_buffer;
  localparam logic [127:0] ALLF = '1;
  localparam logic [3:0] CLR = 4'hC;
  localparam logic [3:0] BS  = 4'hE;
  localparam logic [3:0] ENT = 4'hF;

  typedef struct {
    logic [127:0] v;
    logic [5:0]   c;
    logic         cf;
    logic         er;
    logic         to;
    string        tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  keypad_entry_if kif();

  keypad_entry_buffer #(
    .MAX_DIGITS(32),
    .MIN_DIGITS(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .kp(kif.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] padv(
    input logic [127:0] d, input int n);
    return (ALLF << (4 * n)) | d;
  endfunction

  task automatic check(input exp_t e);
    n_cmp++;
    if (kif.input_value !== e.v || kif.digit_count !== e.c ||
        kif.confirm !== e.cf || kif.entry_error !== e.er ||
        kif.entry_timeout !== e.to) begin
      n_bad++;
      $display("FAIL %s: got v=%h c=%0d cf=%b er=%b to=%b exp v=%h c=%0d cf=%b er=%b to=%b",
        e.tag, kif.input_value, kif.digit_count, kif.confirm,
        kif.entry_error, kif.entry_timeout,
        e.v, e.c, e.cf, e.er, e.to);
    end
  endtask

  // Monitor: after each edge, compare against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) check(q.pop_front());
  end

  task automatic step(input logic kv, input logic [3:0] code,
    input logic lk, input logic [127:0] v, input logic [5:0] c,
    input logic cf, input logic er, input logic to,
    input string tag);
    exp_t e;
    @(negedge clk);
    kif.key_valid = kv;
    kif.key_code  = code;
    kif.lock      = lk;
    e.v = v; e.c = c; e.cf = cf; e.er = er; e.to = to;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic key(input logic [3:0] code,
    input logic [127:0] v, input logic [5:0] c, input string tag);
    step(1'b1, code, 1'b0, v, c, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic idle(input logic [127:0] v, input logic [5:0] c,
    input logic to, input string tag);
    step(1'b0, 4'h0, 1'b0, v, c, 1'b0, 1'b0, to, tag);
  endtask

  initial begin
    exp_t r;
    kif.key_valid = 1'b0;
    kif.key_code  = 4'h0;
    kif.lock      = 1'b0;
    r.v = ALLF; r.c = 6'd0; r.cf = 1'b0; r.er = 1'b0; r.to = 1'b0;
    repeat (3) @(negedge clk);
    r.tag = "reset";
    check(r);
    rst_n = 1'b1;

    key(4'h1, padv(128'h1, 1), 6'd1, "k1");
    key(4'h2, padv(128'h12, 2), 6'd2, "k12");
    key(4'h3, padv(128'h123, 3), 6'd3, "k123");
    key(4'h4, padv(128'h1234, 4), 6'd4, "k1234");
    step(1'b1, ENT, 1'b0, padv(128'h1234, 4), 6'd4,
      1'b1, 1'b0, 1'b0, "enter_ok");
    idle(ALLF, 6'd0, 1'b0, "post_confirm");

    key(4'h5, padv(128'h5, 1), 6'd1, "k5");
    key(4'h6, padv(128'h56, 2), 6'd2, "k56");
    key(4'h7, padv(128'h567, 3), 6'd3, "k567");
    step(1'b1, ENT, 1'b0, padv(128'h567, 3), 6'd3,
      1'b0, 1'b1, 1'b0, "enter_short");
    key(CLR, ALLF, 6'd0, "clr_a");

    key(4'h9, padv(128'h9, 1), 6'd1, "k9");
    key(4'h8, padv(128'h98, 2), 6'd2, "k98");
    key(4'h7, padv(128'h987, 3), 6'd3, "k987");
    key(4'h6, padv(128'h9876, 4), 6'd4, "k9876");
    key(4'hA, padv(128'h9876, 4), 6'd4, "ignored_a");
    key(BS, padv(128'h987, 3), 6'd3, "bs1");
    key(BS, padv(128'h98, 2), 6'd2, "bs2");
    key(CLR, ALLF, 6'd0, "clr_b");
    key(CLR, ALLF, 6'd0, "clr_empty");
    key(BS, ALLF, 6'd0, "bs_empty");
    step(1'b1, ENT, 1'b0, ALLF, 6'd0, 1'b0, 1'b1, 1'b0,
      "enter_empty");

    for (int i = 1; i <= 32; i++)
      key(4'h5, padv({32{4'h5}} >> (4 * (32 - i)), i), 6'(i),
        "fill5");
    step(1'b1, 4'h5, 1'b0, {32{4'h5}}, 6'd32, 1'b0, 1'b1, 1'b0,
      "digit33");
    step(1'b1, ENT, 1'b0, {32{4'h5}}, 6'd32, 1'b1, 1'b0, 1'b0,
      "enter_full");
    idle(ALLF, 6'd0, 1'b0, "post_full");

    key(4'h1, padv(128'h1, 1), 6'd1, "to_k1");
    for (int i = 0; i < 15; i++)
      idle(padv(128'h1, 1), 6'd1, 1'b0, "to_wait");
    idle(ALLF, 6'd0, 1'b1, "timeout");
    idle(ALLF, 6'd0, 1'b0, "post_timeout");

    key(4'h1, padv(128'h1, 1), 6'd1, "race_k1");
    for (int i = 0; i < 15; i++)
      idle(padv(128'h1, 1), 6'd1, 1'b0, "race_wait");
    key(4'h2, padv(128'h12, 2), 6'd2, "race_k2");
    idle(padv(128'h12, 2), 6'd2, 1'b0, "race_after");
    key(CLR, ALLF, 6'd0, "clr_c");

    key(4'h7, padv(128'h7, 1), 6'd1, "lk_k7");
    step(1'b1, 4'h1, 1'b1, padv(128'h7, 1), 6'd1, 0, 0, 0, "lk1");
    step(1'b1, 4'h2, 1'b1, padv(128'h7, 1), 6'd1, 0, 0, 0, "lk2");
    step(1'b1, 4'h3, 1'b1, padv(128'h7, 1), 6'd1, 0, 0, 0, "lk3");
    step(1'b1, 4'h4, 1'b1, padv(128'h7, 1), 6'd1, 0, 0, 0, "lk4");
    step(1'b1, ENT, 1'b1, padv(128'h7, 1), 6'd1, 0, 0, 0, "lk_ent");
    for (int i = 0; i < 15; i++)
      step(1'b0, 4'h0, 1'b1, padv(128'h7, 1), 6'd1, 0, 0, 0,
        "lk_hold");
    for (int i = 0; i < 15; i++)
      idle(padv(128'h7, 1), 6'd1, 1'b0, "unlk_wait");
    idle(ALLF, 6'd0, 1'b1, "unlk_timeout");

    key(4'h1, padv(128'h1, 1), 6'd1, "r_k1");
    key(4'h2, padv(128'h12, 2), 6'd2, "r_k2");
    key(4'h3, padv(128'h123, 3), 6'd3, "r_k3");
    key(4'h4, padv(128'h1234, 4), 6'd4, "r_k4");
    step(1'b1, ENT, 1'b0, padv(128'h1234, 4), 6'd4,
      1'b1, 1'b0, 1'b0, "r_enter");
    @(negedge clk);
    kif.key_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    r.tag = "reset_in_confirm";
    check(r);
    @(negedge clk);
    rst_n = 1'b1;
    idle(ALLF, 6'd0, 1'b0, "after_rst1");
    idle(ALLF, 6'd0, 1'b0, "after_rst2");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending exp 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/keypad_entry_buffer.md
# keypad_entry_buffer

Assembles the 128-bit `input_value` word consumed by the doorlock password comparators from a stream of single-key events. Digits are packed as 4-bit nibbles behind an all-ones pad, with backspace, clear, idle timeout and lockout handling. On a valid ENTER the block issues a one-cycle `confirm` strobe while `input_value` holds the entered code, then clears itself for the next entry.

## Interface
- `MAX_DIGITS`, 32: buffer capacity in digits; 4*`MAX_DIGITS` must equal 128.
- `MIN_DIGITS`, 4: fewest digits accepted by ENTER.
- `TIMEOUT_CYCLES`, 5_000_000: idle cycles before a partial entry is discarded.
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `key_valid`  input  1  one-cycle strobe; `key_code` is valid in this cycle.
- `key_code`  input  4  0x0–0x9 digit, 0xC CLEAR, 0xE BACKSPACE, 0xF ENTER; 0xA, 0xB, 0xD are ignored.
- `lock`  input  1  lockout active; all keys are ignored while high.
- `input_value`  output  128  packed entry, newest digit in [3:0], unused nibbles 0xF.
- `digit_count`  output  6  digits currently held (0..32).
- `confirm`  output  1  one-cycle pulse: `input_value` is a complete entry.
- `entry_error`  output  1  one-cycle pulse: a key was rejected.
- `entry_timeout`  output  1  one-cycle pulse: a partial entry was discarded by the idle timer.

## Operation
- Reset values: `input_value` = 128'hFFFF…F, `digit_count` = 0, `confirm` = 0, `entry_error` = 0, `entry_timeout` = 0, state = EMPTY, idle counter = 0.
- States:
  - EMPTY: `digit_count` = 0.
  - ENTRY: `digit_count` > 0.
  - CONFIRM: lasts exactly one cycle.
- Digit key, count < 32: `input_value` <= {`input_value`[123:0], `key_code`}, count +1. EMPTY→ENTRY.
- Digit key, count = 32: buffer unchanged, `entry_error` pulse.
- BACKSPACE, count > 0: `input_value` <= {4'hF, `input_value`[127:4]}, count −1. ENTRY→EMPTY when count reaches 0.
- BACKSPACE, count = 0: no effect, no error.
- CLEAR: buffer to the reset pattern, count 0, state EMPTY. No error, even when already empty.
- ENTER, count ≥ `MIN_DIGITS`: state→CONFIRM with buffer unchanged.
- ENTER, count < `MIN_DIGITS`: buffer unchanged, `entry_error` pulse.
- CONFIRM cycle: `confirm` = 1 and `input_value`/`digit_count` hold the entered code. On the next edge the buffer goes to the reset pattern, count 0, state EMPTY.
- A key arriving while in CONFIRM is dropped silently, with no error.
- Ignored codes (0xA, 0xB, 0xD) produce no state change and no error.
- `lock` = 1: `key_valid` is ignored and the idle counter holds. The buffer contents are kept. `lock` does not cancel a CONFIRM already in progress.
- Idle timer:
  - Counts only in ENTRY with `lock` = 0.
  - Resets to 0 on any accepted or rejected key, and on leaving ENTRY.
  - On reaching `TIMEOUT_CYCLES`−1 with no key that cycle: buffer cleared, state EMPTY, `entry_timeout` pulse.
  - A key arriving in the same cycle the timer expires wins: the key is processed and the timer resets.
- Zero-padding is forbidden: the 0xF pad distinguishes "12" from "0012".

## Timing
- All outputs are registered. A key sampled at edge N is reflected in `input_value`/`digit_count` after edge N.
- ENTER sampled at edge N: `confirm` is high for the cycle after edge N. The buffer clears at edge N+1.
- `entry_error` and `entry_timeout` are high for exactly one cycle, aligned with the register update.
- At most one of `confirm`, `entry_error`, `entry_timeout` is high in any cycle.
- Back-to-back `key_valid` on consecutive cycles is fully supported, one key per cycle.
- `rst_n` low at any time, including during CONFIRM, forces all reset values immediately. No `confirm` pulse is emitted after reset release.

## Test plan
- Reset, then keys 1,2,3,4,ENTER → `input_value` = 128'hFFFF…F1234 and `confirm` = 1 for one cycle with `digit_count` = 4; next cycle `input_value` = all F, count 0.
- Keys 5,6,7 then ENTER → `entry_error` pulse; `input_value` = …FFF567, count 3, no `confirm`.
- Keys 9,8,7,6,BACKSPACE,BACKSPACE,CLEAR → after the BACKSPACEs `input_value` = …FF98, count 2; after CLEAR all F, count 0.
- 32 digits of 0x5, then a 33rd digit → `input_value` = 128'h5555…5, count 32, `entry_error` pulse; ENTER → `confirm`.
- With `TIMEOUT_CYCLES` = 16: key 1, then idle → `entry_timeout` pulses on idle cycle 16 and the buffer clears. Repeat with key 2 on the expiry cycle → no timeout, count 2.
- `lock` = 1 during keys 1,2,3,4,ENTER → no change, no pulses. Assert `rst_n` low during a CONFIRM cycle → outputs reset immediately, no further `confirm`.
